// File: rtl/nc_context_ctrl_if.sv
// Parser-side and nC_decoding-side signals of the neighbour total_coeff context controller.
// The pcm_mb_in member exists only when NC_PCM_FILL_EN is defined.
interface nc_context_ctrl_if #(
    parameter int MB_X_BITS = 7,
    parameter int MB_Y_BITS = 8
);
    logic                 start_mb_in;
    logic [MB_X_BITS-1:0] mb_x_in;
    logic [MB_Y_BITS-1:0] mb_y_in;
    logic                 luma_wr_in;
    logic [3:0]           luma_idx_in;
    logic                 cb_wr_in;
    logic                 cr_wr_in;
    logic [1:0]           chroma_idx_in;
    logic [4:0]           total_coeff_in;
    logic                 mb_done_in;
`ifdef NC_PCM_FILL_EN
    logic                 pcm_mb_in;
`endif
    logic                 ready_out;
    logic                 ctx_valid_out;
    logic [31:0]          nC_up_mb_out;
    logic [31:0]          nC_left_mb_out;
    logic [127:0]         nC_curr_mb_out;
    logic [15:0]          nC_cb_up_mb_out;
    logic [15:0]          nC_cb_left_mb_out;
    logic [31:0]          nC_cb_curr_mb_out;
    logic [15:0]          nC_cr_up_mb_out;
    logic [15:0]          nC_cr_left_mb_out;
    logic [31:0]          nC_cr_curr_mb_out;

    modport master (
        output start_mb_in, mb_x_in, mb_y_in, luma_wr_in, luma_idx_in,
               cb_wr_in, cr_wr_in, chroma_idx_in, total_coeff_in, mb_done_in,
`ifdef NC_PCM_FILL_EN
        output pcm_mb_in,
`endif
        input  ready_out, ctx_valid_out, nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
               nC_cb_up_mb_out, nC_cb_left_mb_out, nC_cb_curr_mb_out,
               nC_cr_up_mb_out, nC_cr_left_mb_out, nC_cr_curr_mb_out
    );

    modport slave (
        input  start_mb_in, mb_x_in, mb_y_in, luma_wr_in, luma_idx_in,
               cb_wr_in, cr_wr_in, chroma_idx_in, total_coeff_in, mb_done_in,
`ifdef NC_PCM_FILL_EN
        input  pcm_mb_in,
`endif
        output ready_out, ctx_valid_out, nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
               nC_cb_up_mb_out, nC_cb_left_mb_out, nC_cb_curr_mb_out,
               nC_cr_up_mb_out, nC_cr_left_mb_out, nC_cr_curr_mb_out
    );
endinterface

// File: rtl/nc_context_ctrl.sv
// Neighbour total_coeff context for nC_decoding: current MB counts, up line buffer, left registers.
// Latency: start accepted in IDLE gives ctx_valid_out three cycles later; commit takes one cycle.
// Backpressure: ready_out low outside IDLE, starts ignored then. NC_PCM_FILL_EN adds pcm_mb_in.
module nc_context_ctrl #(
    parameter int PIC_WIDTH_MBS = 120,
    parameter int LB_WIDTH      = 64,
    parameter int MB_X_BITS     = 7,
    parameter int MB_Y_BITS     = 8
) (
    input logic              clk,
    input logic              rst,
    nc_context_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_ACTIVE, S_COMMIT} state_t;

    state_t               state_q, state_d;
    logic                 start_acc, lb_rd, ld_up, act, commit;
    logic                 pcm_fill;
    logic                 ready_q, valid_q;
    logic [MB_X_BITS-1:0] mb_x_q;
    logic [MB_Y_BITS-1:0] mb_y_q;
    logic [15:0][7:0]     luma_q;
    logic [3:0][7:0]      cb_q, cr_q;
    logic [31:0]          up_luma_q, left_luma_q;
    logic [15:0]          up_cb_q, up_cr_q, left_cb_q, left_cr_q;
    logic [LB_WIDTH-1:0]  lb_mem [PIC_WIDTH_MBS];
    logic [LB_WIDTH-1:0]  lb_rdata_q;
    logic [LB_WIDTH-1:0]  commit_word;

`ifdef NC_PCM_FILL_EN
    assign pcm_fill = bus.pcm_mb_in;
`else
    assign pcm_fill = 1'b0;
`endif

    function automatic logic [7:0] clamp_tc(input logic [4:0] tc);
        return (tc > 5'd16) ? 8'd16 : {3'b000, tc};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        lb_rd     = 1'b0;
        ld_up     = 1'b0;
        act       = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE:    if (bus.start_mb_in) begin
                           state_d   = S_RD;
                           start_acc = 1'b1;
                       end
            S_RD:      begin lb_rd = 1'b1; state_d = S_RD_WAIT; end
            S_RD_WAIT: begin ld_up = 1'b1; state_d = S_ACTIVE; end
            S_ACTIVE:  begin
                           act = 1'b1;
                           if (bus.mb_done_in) state_d = S_COMMIT;
                       end
            S_COMMIT:  begin commit = 1'b1; state_d = S_IDLE; end
            default:   state_d = S_IDLE;
        endcase
    end

    // Bottom-edge word, MSB-first, so each up field already has byte k = block at x=k.
    assign commit_word = {luma_q[15], luma_q[14], luma_q[11], luma_q[10],
                          cb_q[3], cb_q[2], cr_q[3], cr_q[2]};

    // Line buffer has no reset: the mb_y==0 bypass guarantees it is written before use.
    always_ff @(posedge clk) begin
        if (lb_rd)  lb_rdata_q      <= lb_mem[mb_x_q];
        if (commit) lb_mem[mb_x_q]  <= commit_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            luma_q      <= '0;
            cb_q        <= '0;
            cr_q        <= '0;
            up_luma_q   <= '0;
            up_cb_q     <= '0;
            up_cr_q     <= '0;
            left_luma_q <= '0;
            left_cb_q   <= '0;
            left_cr_q   <= '0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            valid_q <= (state_d == S_ACTIVE);
            if (start_acc) begin
                mb_x_q <= bus.mb_x_in;
                mb_y_q <= bus.mb_y_in;
                luma_q <= '0;
                cb_q   <= '0;
                cr_q   <= '0;
            end
            if (ld_up) begin
                if (mb_y_q == '0) begin
                    up_luma_q <= '0;
                    up_cb_q   <= '0;
                    up_cr_q   <= '0;
                end else begin
                    up_luma_q <= lb_rdata_q[63:32];
                    up_cb_q   <= lb_rdata_q[31:16];
                    up_cr_q   <= lb_rdata_q[15:0];
                end
                if (mb_x_q == '0) begin
                    left_luma_q <= '0;
                    left_cb_q   <= '0;
                    left_cr_q   <= '0;
                end
            end
            if (act) begin
                if (bus.luma_wr_in) luma_q[bus.luma_idx_in]  <= clamp_tc(bus.total_coeff_in);
                if (bus.cb_wr_in)   cb_q[bus.chroma_idx_in]  <= clamp_tc(bus.total_coeff_in);
                if (bus.cr_wr_in)   cr_q[bus.chroma_idx_in]  <= clamp_tc(bus.total_coeff_in);
                // I_PCM: every block counts as 16, overriding any same-cycle write.
                if (bus.mb_done_in && pcm_fill) begin
                    luma_q <= {16{8'd16}};
                    cb_q   <= {4{8'd16}};
                    cr_q   <= {4{8'd16}};
                end
            end
            if (commit) begin
                left_luma_q <= {luma_q[15], luma_q[13], luma_q[7], luma_q[5]};
                left_cb_q   <= {cb_q[3], cb_q[1]};
                left_cr_q   <= {cr_q[3], cr_q[1]};
            end
        end
    end

    assign bus.ready_out         = ready_q;
    assign bus.ctx_valid_out     = valid_q;
    assign bus.nC_up_mb_out      = up_luma_q;
    assign bus.nC_left_mb_out    = left_luma_q;
    assign bus.nC_curr_mb_out    = luma_q;
    assign bus.nC_cb_up_mb_out   = up_cb_q;
    assign bus.nC_cb_left_mb_out = left_cb_q;
    assign bus.nC_cb_curr_mb_out = cb_q;
    assign bus.nC_cr_up_mb_out   = up_cr_q;
    assign bus.nC_cr_left_mb_out = left_cr_q;
    assign bus.nC_cr_curr_mb_out = cr_q;
endmodule
